rom_boot_loader: RTL and testbench

Boot-copy initiator driving the instruction ROM's synchronous read port (CK/CS/OE/A/DO, 1-cycle read latency) from the requester side. On a start pulse it streams a contiguous block of ROM words into the SoC memory write port through a valid/ready interface. It sits beside the ROM in TOP and is released by the reset sequencer before the CPU leaves reset. A 2-entry buffer absorbs write back-pressure, so sustained throughput is 1 word/cycle.

---
 rtl/rom_boot_pkg.sv | 13 +
 rtl/rom_bl_fifo.sv | 51 +++++
 rtl/rom_boot_loader.sv | 103 ++++++++++
 tb/tb_rom_boot_loader.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_boot_pkg.sv
// Shared types and constants for the ROM boot-copy engine.
package rom_boot_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    localparam int unsigned ROM_LAT   = 1;
    localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/rom_bl_fifo.sv
// Small synchronous FIFO that absorbs write back-pressure between ROM reads and the sink.
module rom_bl_fifo
    import rom_boot_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head
);
    localparam int unsigned PW = $clog2(BUF_DEPTH);

    logic [DW-1:0] mem_q [BUF_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_ok, push_ok;

    always_comb begin
        pop_ok  = pop && (count_q != '0);
        push_ok = push && ((count_q != CW'(BUF_DEPTH)) || pop_ok);
        count   = count_q;
        head    = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    // The issue throttle upstream guarantees a free slot for every returning read.
    always_ff @(posedge clk) begin
        if (!rst) assert (!push || push_ok);
    end

endmodule

// File: rtl/rom_boot_loader.sv
// Copies a contiguous block of ROM words to the SoC write port on a start pulse.
module rom_boot_loader
    import rom_boot_pkg::*;
#(
    parameter int unsigned ROM_AW = 12,
    parameter int unsigned DW     = 32,
    parameter int unsigned DST_AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROM_AW-1:0] src_base,
    input  logic [DST_AW-1:0] dst_base,
    input  logic [ROM_AW:0]   word_cnt,
    output logic              busy,
    output logic              done,
    output logic              ROM_CS,
    output logic              ROM_OE,
    output logic [ROM_AW-1:0] ROM_A,
    input  logic [DW-1:0]     ROM_DO,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [DST_AW-1:0] wr_addr,
    output logic [DW-1:0]     wr_data
);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] src_q;
    logic [DST_AW-1:0] dst_q;
    logic [ROM_AW:0]   cnt_q, issued_q, written_q;
    logic [ROM_LAT-1:0] pend_q;
    logic [CW-1:0]     buf_count;
    logic [DW-1:0]     buf_head;
    logic              pop, last_pop, issue_room;

    rom_bl_fifo #(
        .DW(DW),
        .CW(CW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (pend_q[ROM_LAT-1]),
        .pop  (pop),
        .din  (ROM_DO),
        .count(buf_count),
        .head (buf_head)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = (word_cnt == '0) ? StFin : StRun;
            StRun:  if (last_pop) state_d = StFin;
            StFin:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q == StRun);
        done     = (state_q == StFin);
        ROM_OE   = busy;
        wr_valid = (buf_count != '0);
        pop      = wr_valid && wr_ready;
        last_pop = pop && ((written_q + 1'b1) == cnt_q);
        // Reads in flight already own a slot; a same-cycle pop frees one.
        issue_room = (int'(buf_count) + $countones(pend_q) - int'(pop)) < int'(BUF_DEPTH);
        ROM_CS   = busy && (issued_q < cnt_q) && issue_room;
        ROM_A    = src_q + issued_q[ROM_AW-1:0];
        wr_addr  = dst_q + DST_AW'({written_q, 2'b00});
        wr_data  = wr_valid ? buf_head : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            issued_q  <= '0;
            written_q <= '0;
            pend_q    <= '0;
        end else begin
            pend_q <= ROM_LAT'({pend_q, ROM_CS});
            if ((state_q == StIdle) && start) begin
                src_q     <= src_base;
                dst_q     <= dst_base;
                cnt_q     <= word_cnt;
                issued_q  <= '0;
                written_q <= '0;
            end else begin
                if (ROM_CS) issued_q <= issued_q + 1'b1;
                if (pop) written_q <= written_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Directed self-checking bench for rom_boot_loader with a behavioural 1-cycle ROM.
module tb_rom_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] src_base = '0;
    logic [31:0] dst_base = '0;
    logic [12:0] word_cnt = '0;
    logic        busy, done, ROM_CS, ROM_OE, wr_valid;
    logic [11:0] ROM_A;
    logic [31:0] ROM_DO = '0;
    logic        wr_ready = 1'b1;
    logic [31:0] wr_addr, wr_data;

    logic [31:0] rom_mem [4096];

    int nchk = 0;
    int nerr = 0;
    int a_log[$];
    int wa_log[$];
    int wd_log[$];
    int first_cs, first_valid, last_wr, done_cycle, done_count;
    int busy_fall, busy_cycles, cs_before_pop, unstable;

    rom_boot_loader #(
        .ROM_AW(12),
        .DW    (32),
        .DST_AW(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .src_base(src_base),
        .dst_base(dst_base),
        .word_cnt(word_cnt),
        .busy    (busy),
        .done    (done),
        .ROM_CS  (ROM_CS),
        .ROM_OE  (ROM_OE),
        .ROM_A   (ROM_A),
        .ROM_DO  (ROM_DO),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ROM_CS) ROM_DO <= rom_mem[ROM_A];
    end

    // Start sampled at edge 0; cycle c is the interval after edge c. Logs activity only.
    task automatic run_copy(input int src, input int dst, input int cnt, input int stall_lo,
                            input int stall_hi, input int poke, input int max_cycles);
        logic        pv, pr, hs, popped, was_busy;
        logic [31:0] pa, pd;
        a_log.delete();
        wa_log.delete();
        wd_log.delete();
        first_cs = -1; first_valid = -1; last_wr = -1; done_cycle = -1; done_count = 0;
        busy_fall = -1; busy_cycles = 0; cs_before_pop = 0; unstable = 0;
        pv = 1'b0; pr = 1'b1; pa = '0; pd = '0; popped = 1'b0; was_busy = 1'b0;
        src_base = 12'(src);
        dst_base = 32'(dst);
        word_cnt = 13'(cnt);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        src_base = 12'h5A5;
        dst_base = 32'hDEAD_0000;
        word_cnt = 13'd9;
        for (int c = 1; c <= max_cycles; c++) begin
            wr_ready = (c >= stall_lo && c <= stall_hi) ? 1'b0 : 1'b1;
            start    = (c == poke);
            if (c == poke) begin
                src_base = 12'd100;
                word_cnt = 13'd7;
            end
            @(negedge clk);
            hs = wr_valid && wr_ready;
            if (ROM_CS) begin
                a_log.push_back(int'(ROM_A));
                if (first_cs < 0) first_cs = c;
                if (!popped && !hs) cs_before_pop++;
            end
            if (pv && !pr && (!wr_valid || wr_addr !== pa || wr_data !== pd)) unstable++;
            if (wr_valid && first_valid < 0) first_valid = c;
            if (hs) begin
                wa_log.push_back(int'(wr_addr));
                wd_log.push_back(int'(wr_data));
                last_wr = c;
                popped  = 1'b1;
            end
            if (busy) busy_cycles++;
            if (was_busy && !busy && busy_fall < 0) busy_fall = c;
            was_busy = busy;
            if (done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
            pv = wr_valid; pr = wr_ready; pa = wr_addr; pd = wr_data;
            @(posedge clk); #1;
            if (done_cycle >= 0 && c >= done_cycle + 2) break;
        end
        start    = 1'b0;
        wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        nchk++;
        if ({busy, done, ROM_CS, ROM_OE, wr_valid} !== 5'b0) begin
            nerr++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, ROM_CS, ROM_OE, wr_valid});
        end
        nchk++;
        if (ROM_A !== 12'd0 || wr_addr !== 32'd0 || wr_data !== 32'd0) begin
            nerr++;
            $display("FAIL reset_data: got A=%0h addr=%0h data=%0h expected 0 0 0",
                     ROM_A, wr_addr, wr_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_copy(0, 'h1000, 4, -1, -1, -1, 30);
        nchk++;
        if (first_cs !== 1 || a_log.size() == 0 || a_log[0] !== 0) begin
            nerr++;
            $display("FAIL basic_first_issue: got cycle %0d expected cycle 1 at A=0", first_cs);
        end
        nchk++;
        if (wa_log.size() !== 4) begin
            nerr++;
            $display("FAIL basic_count: got %0d writes expected 4", wa_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            nchk++;
            if (i >= wa_log.size() || wa_log[i] !== 'h1000 + 4 * i || wd_log[i] !== 5 * i) begin
                nerr++;
                $display("FAIL basic_write[%0d]: got (%0h,%0d) expected (%0h,%0d)", i,
                         (i < wa_log.size()) ? wa_log[i] : -1,
                         (i < wd_log.size()) ? wd_log[i] : -1, 'h1000 + 4 * i, 5 * i);
            end
        end
        nchk++;
        if (first_valid !== 3 || last_wr !== 6) begin
            nerr++;
            $display("FAIL basic_write_window: got %0d..%0d expected 3..6", first_valid, last_wr);
        end
        nchk++;
        if (done_cycle !== 7 || done_count !== 1 || busy_fall !== 7 || busy_cycles !== 6) begin
            nerr++;
            $display("FAIL basic_done: got done@%0d x%0d fall@%0d busy=%0d expected 7 x1 7 6",
                     done_cycle, done_count, busy_fall, busy_cycles);
        end
    endtask

    task automatic test_stall();
        run_copy(0, 'h1000, 4, 3, 8, -1, 40);
        nchk++;
        if (cs_before_pop !== 2) begin
            nerr++;
            $display("FAIL stall_issue_limit: got %0d CS before first pop expected 2", cs_before_pop);
        end
        nchk++;
        if (unstable !== 0) begin
            nerr++;
            $display("FAIL stall_stable: got %0d unstable cycles expected 0", unstable);
        end
        nchk++;
        if (wa_log.size() !== 4 || a_log.size() !== 4) begin
            nerr++;
            $display("FAIL stall_count: got %0d writes %0d reads expected 4 4",
                     wa_log.size(), a_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            nchk++;
            if (i >= wa_log.size() || wa_log[i] !== 'h1000 + 4 * i || wd_log[i] !== 5 * i) begin
                nerr++;
                $display("FAIL stall_write[%0d]: got (%0h,%0d) expected (%0h,%0d)", i,
                         (i < wa_log.size()) ? wa_log[i] : -1,
                         (i < wd_log.size()) ? wd_log[i] : -1, 'h1000 + 4 * i, 5 * i);
            end
        end
        nchk++;
        if (first_valid !== 3 || done_cycle !== 13 || done_count !== 1) begin
            nerr++;
            $display("FAIL stall_timing: got valid@%0d done@%0d x%0d expected 3 13 x1",
                     first_valid, done_cycle, done_count);
        end
    endtask

    task automatic test_wrap();
        int exp_a [3] = '{4094, 4095, 0};
        int exp_d [3] = '{20470, 20475, 0};
        run_copy(4094, 0, 3, -1, -1, -1, 30);
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (i >= a_log.size() || i >= wd_log.size() || a_log[i] !== exp_a[i] ||
                wd_log[i] !== exp_d[i] || wa_log[i] !== 4 * i) begin
                nerr++;
                $display("FAIL wrap[%0d]: got A=%0d data=%0d expected A=%0d data=%0d addr=%0d", i,
                         (i < a_log.size()) ? a_log[i] : -1,
                         (i < wd_log.size()) ? wd_log[i] : -1, exp_a[i], exp_d[i], 4 * i);
            end
        end
        nchk++;
        if (a_log.size() !== 3 || wd_log.size() !== 3 || done_cycle !== 6) begin
            nerr++;
            $display("FAIL wrap_count: got %0d reads %0d writes done@%0d expected 3 3 6",
                     a_log.size(), wd_log.size(), done_cycle);
        end
    endtask

    task automatic test_zero();
        run_copy(0, 'h40, 0, -1, -1, -1, 10);
        nchk++;
        if (a_log.size() !== 0 || first_valid !== -1 || busy_cycles !== 0) begin
            nerr++;
            $display("FAIL zero_activity: got %0d CS, valid@%0d, busy %0d cycles expected none",
                     a_log.size(), first_valid, busy_cycles);
        end
        nchk++;
        if (done_cycle !== 1 || done_count !== 1) begin
            nerr++;
            $display("FAIL zero_done: got done@%0d x%0d expected 1 x1", done_cycle, done_count);
        end
    endtask

    task automatic test_reset_mid();
        int nw = 0;
        int seen = 0;
        src_base = 12'd0;
        dst_base = 32'h2000;
        word_cnt = 13'd10;
        wr_ready = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (wr_valid && wr_ready) nw++;
            @(posedge clk); #1;
        end
        nchk++;
        if (nw !== 2) begin
            nerr++;
            $display("FAIL rstmid_pre_writes: got %0d expected 2", nw);
        end
        wr_ready = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        nchk++;
        if ({busy, done, ROM_CS, ROM_OE, wr_valid} !== 5'b0) begin
            nerr++;
            $display("FAIL rstmid_ctrl: got %b expected 00000", {busy, done, ROM_CS, ROM_OE, wr_valid});
        end
        nchk++;
        if (ROM_A !== 12'd0 || wr_addr !== 32'd0 || wr_data !== 32'd0) begin
            nerr++;
            $display("FAIL rstmid_data: got A=%0h addr=%0h data=%0h expected 0 0 0",
                     ROM_A, wr_addr, wr_data);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done || busy || wr_valid) seen++;
        end
        nchk++;
        if (seen !== 0) begin
            nerr++;
            $display("FAIL rstmid_quiet: got %0d active cycles expected 0", seen);
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        run_copy(5, 'h3000, 1, -1, -1, -1, 20);
        nchk++;
        if (wa_log.size() !== 1 || wa_log[0] !== 'h3000 || wd_log[0] !== 25 || done_cycle !== 4) begin
            nerr++;
            $display("FAIL rstmid_restart: got %0d writes (%0h,%0d) done@%0d expected 1 (3000,25) 4",
                     wa_log.size(), (wa_log.size() > 0) ? wa_log[0] : -1,
                     (wd_log.size() > 0) ? wd_log[0] : -1, done_cycle);
        end
    endtask

    task automatic test_start_ignored();
        run_copy(0, 'h1000, 4, -1, -1, 2, 30);
        for (int i = 0; i < 4; i++) begin
            nchk++;
            if (i >= a_log.size() || i >= wd_log.size() || a_log[i] !== i || wd_log[i] !== 5 * i ||
                wa_log[i] !== 'h1000 + 4 * i) begin
                nerr++;
                $display("FAIL ignore_start[%0d]: got A=%0d data=%0d expected A=%0d data=%0d", i,
                         (i < a_log.size()) ? a_log[i] : -1,
                         (i < wd_log.size()) ? wd_log[i] : -1, i, 5 * i);
            end
        end
        nchk++;
        if (a_log.size() !== 4 || wd_log.size() !== 4 || done_cycle !== 7 || done_count !== 1) begin
            nerr++;
            $display("FAIL ignore_start_done: got %0d reads %0d writes done@%0d x%0d expected 4 4 7 x1",
                     a_log.size(), wd_log.size(), done_cycle, done_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 32'(i * 5);
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero();
        test_reset_mid();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
